// File: rtl/somador_serial.sv
// somador_serial: bit-serial adder/subtractor.
// Operands are consumed LSB-first, one bit per clock, through a single
// full-adder cell and a carry flop. Start/done handshake; the result is
// held until the next completed operation.
module somador_serial #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] R,
    output logic             Cout,
    output logic             overflow
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIM  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             sum_bit;
    logic             carry_out;
    logic             last_bit;
    logic             accept;

    // Full-adder cell on the current LSBs, plus handshake qualifiers
    always_comb begin
        sum_bit   = opa_q[0] ^ opb_q[0] ^ carry_q;
        carry_out = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
        last_bit  = (cnt_q == CW'(WIDTH - 1));
        accept    = start && ((state_q == IDLE) || (state_q == FIM));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (last_bit) state_d = FIM;
            FIM:     state_d = start ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state_q == CALC);
        done = (state_q == FIM);
    end

    // Datapath next values: operand latch, serial shift, result capture
    always_comb begin
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        r_d     = r_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept) begin
            opa_d   = A;
            opb_d   = sub ? ~B : B;
            carry_d = sub;
            cnt_d   = '0;
        end else if (state_q == CALC) begin
            acc_d   = {sum_bit, acc_q[WIDTH-1:1]};
            opa_d   = opa_q >> 1;
            opb_d   = opb_q >> 1;
            carry_d = carry_out;
            cnt_d   = cnt_q + CW'(1);
            // Final bit: publish the full result, bypassing the shift
            // register so R is valid in the same cycle as done.
            if (last_bit) begin
                r_d    = {sum_bit, acc_q[WIDTH-1:1]};
                cout_d = carry_out;
                ovf_d  = carry_q ^ carry_out;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            r_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            r_q     <= r_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Result outputs straight from their holding registers
    always_comb begin
        R        = r_q;
        Cout     = cout_q;
        overflow = ovf_q;
    end

endmodule

// File: tb/tb_somador_serial.sv
// Bench for somador_serial: WIDTH=8 and WIDTH=2 instances, a cycle-level
// behavioural model, directed literal cases and randomized traffic.
module tb_somador_serial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start8 = 1'b0, sub8 = 1'b0;
    logic [7:0] A8 = '0, B8 = '0, R8;
    logic       busy8, done8, cout8, ovf8;

    logic       start2 = 1'b0, sub2 = 1'b0;
    logic [1:0] A2 = '0, B2 = '0, R2;
    logic       busy2, done2, cout2, ovf2;

    somador_serial #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .A(A8), .B(B8),
        .busy(busy8), .done(done8), .R(R8), .Cout(cout8), .overflow(ovf8)
    );

    somador_serial #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .A(A2), .B(B2),
        .busy(busy2), .done(done2), .R(R2), .Cout(cout2), .overflow(ovf2)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Arithmetic reference: modular result, raw carry, signed overflow
    function automatic void calc_ref(input int unsigned a, input int unsigned b, input bit s,
                                     input int w, output int unsigned r, output bit c,
                                     output bit o);
        int unsigned mask, bb, tot;
        int sa, sb, res;
        mask = (32'd1 << w) - 1;
        bb   = s ? (~b & mask) : b;
        tot  = a + bb + 32'(s);
        r    = tot & mask;
        c    = tot[w];
        sa   = (a >= (32'd1 << (w - 1))) ? int'(a) - (1 << w) : int'(a);
        sb   = (b >= (32'd1 << (w - 1))) ? int'(b) - (1 << w) : int'(b);
        res  = s ? sa - sb : sa + sb;
        o    = (res > (1 << (w - 1)) - 1) || (res < -(1 << (w - 1)));
    endfunction

    // Model state per instance (0: WIDTH=8, 1: WIDTH=2)
    int          m_left[2] = '{default: 0};
    bit          m_done[2] = '{default: 0};
    int unsigned m_r[2]    = '{default: 0};
    bit          m_c[2]    = '{default: 0};
    bit          m_o[2]    = '{default: 0};
    int unsigned p_r[2]    = '{default: 0};
    bit          p_c[2]    = '{default: 0};
    bit          p_o[2]    = '{default: 0};

    task automatic step(input int k, input bit st, input int unsigned a, input int unsigned b,
                        input bit s, input int w);
        if (m_left[k] > 0) begin
            m_left[k]--;
            m_done[k] = (m_left[k] == 0);
            if (m_done[k]) begin
                m_r[k] = p_r[k];
                m_c[k] = p_c[k];
                m_o[k] = p_o[k];
            end
        end else begin
            m_done[k] = 1'b0;
            if (st) begin
                m_left[k] = w;
                calc_ref(a, b, s, w, p_r[k], p_c[k], p_o[k]);
            end
        end
    endtask

    // Behavioural model advance
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_left[k] = 0; m_done[k] = 0; m_r[k] = 0; m_c[k] = 0; m_o[k] = 0;
            end
        end else begin
            step(0, start8, 32'(A8), 32'(B8), sub8, 8);
            step(1, start2, 32'(A2), 32'(B2), sub2, 2);
        end
    end

    // Cycle-by-cycle compare against the model
    always @(negedge clk) begin
        chk("busy8", 32'(busy8), 32'(m_left[0] > 0));
        chk("done8", 32'(done8), 32'(m_done[0]));
        chk("R8",    32'(R8),    m_r[0]);
        chk("cout8", 32'(cout8), 32'(m_c[0]));
        chk("ovf8",  32'(ovf8),  32'(m_o[0]));
        chk("busy2", 32'(busy2), 32'(m_left[1] > 0));
        chk("done2", 32'(done2), 32'(m_done[1]));
        chk("R2",    32'(R2),    m_r[1]);
        chk("cout2", 32'(cout2), 32'(m_c[1]));
        chk("ovf2",  32'(ovf2),  32'(m_o[1]));
    end

    task automatic op8(input string nm, input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [7:0] er, input logic ec, input logic eo);
        int n, nb;
        @(negedge clk);
        A8 = a; B8 = b; sub8 = s; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        nb = busy8 ? 1 : 0;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
            if (busy8) nb++;
        end
        chk({nm, "_latency"}, n, 8);
        chk({nm, "_busycycles"}, nb, 8);
        chk({nm, "_R"}, 32'(R8), 32'(er));
        chk({nm, "_Cout"}, 32'(cout8), 32'(ec));
        chk({nm, "_ovf"}, 32'(ovf8), 32'(eo));
    endtask

    task automatic op2(input int a, input int b, input bit s);
        int n;
        int unsigned r_exp;
        bit c_exp, o_exp;
        logic [2:0] sum3;
        @(negedge clk);
        A2 = 2'(a); B2 = 2'(b); sub2 = s; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 10) begin
            @(negedge clk);
            n++;
        end
        sum3 = 3'(a) + (s ? 3'((~b) & 3) + 3'd1 : 3'(b));
        calc_ref(a, b, s, 2, r_exp, c_exp, o_exp);
        chk($sformatf("w2_lat a=%0d b=%0d sub=%0d", a, b, s), n, 2);
        chk($sformatf("w2_sum a=%0d b=%0d sub=%0d", a, b, s), 32'({cout2, R2}), 32'(sum3));
        chk($sformatf("w2_ovf a=%0d b=%0d sub=%0d", a, b, s), 32'(ovf2), 32'(o_exp));
    endtask

    initial begin
        int n, saw;
        int unsigned r;
        bit c, o;

        // Pin the reference with hand-computed values
        calc_ref(32'h7F, 32'h01, 1'b0, 8, r, c, o);
        chk("ref_7f_plus_1", {r[7:0], 6'b0, c, o}, {8'h80, 6'b0, 1'b0, 1'b1});
        calc_ref(32'h80, 32'h01, 1'b1, 8, r, c, o);
        chk("ref_80_minus_1", {r[7:0], 6'b0, c, o}, {8'h7F, 6'b0, 1'b1, 1'b1});
        calc_ref(32'h05, 32'h07, 1'b1, 8, r, c, o);
        chk("ref_5_minus_7", {r[7:0], 6'b0, c, o}, {8'hFE, 6'b0, 1'b0, 1'b0});

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy8), 0);
        chk("rst_done", 32'(done8), 0);
        chk("rst_R", 32'(R8), 0);
        rst_n = 1'b1;

        op8("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        op8("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        op8("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // start and operand changes during CALC are ignored
        @(negedge clk);
        A8 = 8'h12; B8 = 8'h34; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; A8 = 8'hFF; B8 = 8'hFF; sub8 = 1'b1;
        repeat (2) @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 20) begin @(negedge clk); n++; end
        chk("ignore_R", 32'(R8), 32'h46);
        chk("ignore_Cout", 32'(cout8), 0);

        // Back-to-back: start held through the done cycle
        @(negedge clk);
        A8 = 8'h10; B8 = 8'h20; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        A8 = 8'h01; B8 = 8'h02;
        n = 0;
        while (!done8 && n < 20) begin @(negedge clk); n++; end
        chk("b2b_first_R", 32'(R8), 32'h30);
        @(negedge clk);
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 20) begin @(negedge clk); n++; end
        chk("b2b_gap", n, 9);
        chk("b2b_second_R", 32'(R8), 32'h03);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        A8 = 8'h55; B8 = 8'h11; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy8), 0);
        chk("arst_done", 32'(done8), 0);
        chk("arst_R", 32'(R8), 0);
        chk("arst_Cout", 32'(cout8), 0);
        chk("arst_ovf", 32'(ovf8), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        saw = 0;
        repeat (12) begin @(negedge clk); if (done8) saw = 1; end
        chk("arst_no_done", saw, 0);
        op8("post_rst", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

        // Exhaustive at WIDTH=2
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 4; a++)
                for (int b = 0; b < 4; b++)
                    op2(a, b, s[0]);

        // Randomized traffic, including start pulses during CALC and rare resets
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start8 = ($urandom_range(0, 2) == 0);
            A8 = 8'($urandom); B8 = 8'($urandom); sub8 = 1'($urandom);
            start2 = ($urandom_range(0, 2) == 0);
            A2 = 2'($urandom); B2 = 2'($urandom); sub2 = 1'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        start8 = 1'b0; start2 = 1'b0;
        repeat (12) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
